lcd_responder: RTL



---
 rtl/lcd_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lcd_responder.sv
// lcd_responder: receive-side HD44780-subset model driven by the bit-banged LCD register word.
//   clk_i        system clock
//   rst_i        synchronous active-high reset; also starts a DDRAM fill
//   lcd_i        LCD register word: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA
//   rd_addr_i    DDRAM debug read address in LCD address space
//   rd_data_o    DDRAM byte at rd_addr_i, one cycle later
//   lcd_rdata_o  {busy, AC} while RW is driven high, else 0
//   busy_o       an operation (exec countdown or clear sweep) is in progress
//   disp_on_o    display-on bit
//   ac_o         address counter
//   wr_strobe_o  one-cycle pulse per DDRAM data write
//   err_o        sticky: a strobe arrived while busy
module lcd_responder #(
    parameter int         EXEC_CYCLES = 4,
    parameter int         HOME_CYCLES = 16,
    parameter logic [7:0] FILL_CHAR   = 8'h20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_i,
    input  logic [6:0]  rd_addr_i,
    output logic [7:0]  rd_data_o,
    output logic [7:0]  lcd_rdata_o,
    output logic        busy_o,
    output logic        disp_on_o,
    output logic [6:0]  ac_o,
    output logic        wr_strobe_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    state_t      state, state_n;
    logic [31:0] lcd_q;
    logic [15:0] cnt, cnt_n;
    logic [6:0]  ac, ac_n, widx;
    logic [7:0]  wdata;
    logic        id, id_n, disp, disp_n, err, err_n, we, wr_n;
    logic [7:0]  mem [0:79];
    logic        unused_bits;

    // line 2 (0x40-0x67) is packed directly after the 40 cells of line 1
    function automatic logic [6:0] to_idx(input logic [6:0] a);
        return a[6] ? {1'b0, a[5:0]} + 7'd40 : a;
    endfunction

    // a column past 0x27 on either line lands at the start of the other line
    function automatic logic [6:0] norm(input logic [6:0] a);
        return (a[5:0] > 6'h27) ? {~a[6], 6'h00} : a;
    endfunction

    function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
        return inc ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
                   : (a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1);
    endfunction

    // EN falling edge on a powered, write-direction word; RW=1 strobes are pure reads
    wire       strobe = lcd_q[10] & ~lcd_i[10] & lcd_q[31] & ~lcd_q[8];
    wire [7:0] dat    = lcd_q[7:0];

    assign unused_bits = ^lcd_q[30:11];
    assign busy_o      = state != IDLE;
    assign ac_o        = ac;
    assign disp_on_o   = disp;
    assign err_o       = err;
    assign lcd_rdata_o = lcd_i[8] ? {busy_o, ac} : 8'h00;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ac_n    = ac;
        id_n    = id;
        disp_n  = disp;
        err_n   = err;
        we      = 1'b0;
        wr_n    = 1'b0;
        widx    = to_idx(ac);
        wdata   = dat;
        case (state)
            IDLE: begin
                if (strobe && (lcd_q[9] || dat != 8'h00)) begin
                    state_n = EXEC;
                    cnt_n   = 16'(EXEC_CYCLES - 1);
                    if (lcd_q[9]) begin
                        we   = 1'b1;
                        wr_n = 1'b1;
                        ac_n = step(ac, id);
                    end else if (dat[7]) begin
                        ac_n = norm(dat[6:0]);
                    end else if (dat[6:4] != 3'b000) begin
                        ac_n = ac;
                    end else if (dat[3]) begin
                        disp_n = dat[2];
                    end else if (dat[2]) begin
                        id_n = dat[1];
                    end else if (dat[1]) begin
                        ac_n  = 7'h00;
                        cnt_n = 16'(HOME_CYCLES - 1);
                    end else begin
                        state_n = CLEAR;
                        cnt_n   = 16'd0;
                    end
                end
            end
            EXEC: begin
                err_n   = err | strobe;
                cnt_n   = cnt - 16'd1;
                state_n = (cnt == 16'd0) ? IDLE : EXEC;
            end
            CLEAR: begin
                err_n = err | strobe;
                we    = 1'b1;
                widx  = cnt[6:0];
                wdata = FILL_CHAR;
                cnt_n = cnt + 16'd1;
                if (cnt == 16'd79) begin
                    state_n = IDLE;
                    ac_n    = 7'h00;
                    id_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= CLEAR;
            cnt         <= 16'd0;
            ac          <= 7'h00;
            id          <= 1'b1;
            disp        <= 1'b0;
            err         <= 1'b0;
            wr_strobe_o <= 1'b0;
            lcd_q       <= 32'h0;
            rd_data_o   <= 8'h00;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ac          <= ac_n;
            id          <= id_n;
            disp        <= disp_n;
            err         <= err_n;
            wr_strobe_o <= wr_n;
            lcd_q       <= lcd_i;
            rd_data_o   <= (rd_addr_i[5:0] < 6'd40) ? mem[to_idx(rd_addr_i)] : FILL_CHAR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we && !rst_i) mem[widx] <= wdata;
    end
endmodule
